// File: rtl/cnna_addr_pkg.sv
// Shared widths, FSM state encoding and address arithmetic for the
// feature-map address generator.
package cnna_addr_pkg;

  localparam int STRIDE_W = 13;
  localparam int ROW_W    = 5;
  localparam int ADDR_W   = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The address space is a ring: the sum wraps modulo 2^ADDR_W with no flag.
  function automatic logic [ADDR_W-1:0] addr_sum(
    input logic [ADDR_W-1:0]   base,
    input logic [ADDR_W-1:0]   prod,
    input logic [STRIDE_W-1:0] col
  );
    return base + prod + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/cnna_fmap_addr_gen_if.sv
// Control handshake, multiplier hookup and address stream of the
// feature-map address generator, bundled for the block boundary.
interface cnna_fmap_addr_gen_if import cnna_addr_pkg::*; ();

  logic                ap_start;
  logic                ap_ready;
  logic                ap_done;
  logic                ap_idle;

  logic [ADDR_W-1:0]   cfg_base;
  logic [STRIDE_W-1:0] cfg_stride;
  logic [ROW_W-1:0]    cfg_rows;
  logic [STRIDE_W-1:0] cfg_cols;

  logic [STRIDE_W-1:0] mul_a;
  logic [ROW_W-1:0]    mul_b;
  logic [ADDR_W-1:0]   mul_p;

  logic [ADDR_W-1:0]   addr_tdata;
  logic                addr_tvalid;
  logic                addr_tlast;
  logic                addr_tready;

  // Controller / multiplier / consumer side.
  modport master (
    output ap_start, cfg_base, cfg_stride, cfg_rows, cfg_cols,
    output mul_p, addr_tready,
    input  ap_ready, ap_done, ap_idle,
    input  mul_a, mul_b,
    input  addr_tdata, addr_tvalid, addr_tlast
  );

  // Address generator side.
  modport slave (
    input  ap_start, cfg_base, cfg_stride, cfg_rows, cfg_cols,
    input  mul_p, addr_tready,
    output ap_ready, ap_done, ap_idle,
    output mul_a, mul_b,
    output addr_tdata, addr_tvalid, addr_tlast
  );

endinterface

// File: rtl/cnna_tile_loop_cnt.sv
// Nested row/column tile counter: column is the inner loop, row the outer.
// last flags the final (rows-1, cols-1) position of the tile.
module cnna_tile_loop_cnt import cnna_addr_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                adv,
  input  logic [ROW_W-1:0]    rows,
  input  logic [STRIDE_W-1:0] cols,
  output logic [ROW_W-1:0]    row,
  output logic [STRIDE_W-1:0] col,
  output logic                last
);

  logic [ROW_W-1:0]    row_q, row_d;
  logic [STRIDE_W-1:0] col_q, col_d;
  logic                col_end;
  logic                row_end;

  assign col_end = (col_q == cols - STRIDE_W'(1));
  assign row_end = (row_q == rows - ROW_W'(1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + STRIDE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = row_end & col_end;

endmodule

// File: rtl/cnna_fmap_addr_gen.sv
// Feature-map address generator: walks a rows x cols tile and streams
// addr = base + row*stride + col through an external multiplier, one per cycle.
module cnna_fmap_addr_gen import cnna_addr_pkg::*; (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  cnna_fmap_addr_gen_if.slave bus
);

  state_e              state_q, state_d;

  logic [ADDR_W-1:0]   base_q, base_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic [ROW_W-1:0]    rows_q, rows_d;
  logic [STRIDE_W-1:0] cols_q, cols_d;

  logic                vld_p1_q, vld_p1_d;
  logic                last_p1_q, last_p1_d;
  logic [STRIDE_W-1:0] mul_a_p1_q, mul_a_p1_d;
  logic [ROW_W-1:0]    mul_b_p1_q, mul_b_p1_d;
  logic [STRIDE_W-1:0] col_p1_q, col_p1_d;

  logic                vld_p2_q, vld_p2_d;
  logic                last_p2_q, last_p2_d;
  logic [ADDR_W-1:0]   tdata_p2_q, tdata_p2_d;

  logic                stall;
  logic                issue;
  logic                cnt_clr;
  logic                ready_c;
  logic                done_c;
  logic [ROW_W-1:0]    cnt_row;
  logic [STRIDE_W-1:0] cnt_col;
  logic                cnt_last;

  // A held beat freezes the whole pipeline, including the loop counters.
  assign stall = vld_p2_q & ~bus.addr_tready;

  cnna_tile_loop_cnt u_loop (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .clr   (cnt_clr),
    .adv   (issue),
    .rows  (rows_q),
    .cols  (cols_q),
    .row   (cnt_row),
    .col   (cnt_col),
    .last  (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    stride_d = stride_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    cnt_clr  = 1'b0;
    issue    = 1'b0;
    ready_c  = 1'b0;
    done_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          base_d   = bus.cfg_base;
          stride_d = bus.cfg_stride;
          rows_d   = bus.cfg_rows;
          cols_d   = bus.cfg_cols;
          cnt_clr  = 1'b1;
          ready_c  = 1'b1;
          state_d  = (bus.cfg_rows == '0 || bus.cfg_cols == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (cnt_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (vld_p2_q & bus.addr_tready & last_p2_q) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_p1_d   = vld_p1_q;
    last_p1_d  = last_p1_q;
    mul_a_p1_d = mul_a_p1_q;
    mul_b_p1_d = mul_b_p1_q;
    col_p1_d   = col_p1_q;
    vld_p2_d   = vld_p2_q;
    last_p2_d  = last_p2_q;
    tdata_p2_d = tdata_p2_q;
    if (!stall) begin
      // Stage 1: present stride and row to the multiplier, carry col alongside.
      vld_p1_d  = issue;
      last_p1_d = issue & cnt_last;
      if (issue) begin
        mul_a_p1_d = stride_q;
        mul_b_p1_d = cnt_row;
        col_p1_d   = cnt_col;
      end
      // Stage 2: product returns combinationally; add base and column.
      vld_p2_d  = vld_p1_q;
      last_p2_d = last_p1_q;
      if (vld_p1_q) tdata_p2_d = addr_sum(base_q, bus.mul_p, col_p1_q);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      stride_q   <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      vld_p1_q   <= 1'b0;
      last_p1_q  <= 1'b0;
      mul_a_p1_q <= '0;
      mul_b_p1_q <= '0;
      col_p1_q   <= '0;
      vld_p2_q   <= 1'b0;
      last_p2_q  <= 1'b0;
      tdata_p2_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      vld_p1_q   <= vld_p1_d;
      last_p1_q  <= last_p1_d;
      mul_a_p1_q <= mul_a_p1_d;
      mul_b_p1_q <= mul_b_p1_d;
      col_p1_q   <= col_p1_d;
      vld_p2_q   <= vld_p2_d;
      last_p2_q  <= last_p2_d;
      tdata_p2_q <= tdata_p2_d;
    end
  end

  // Outputs are forced to their idle values for as long as reset is held.
  assign bus.ap_ready    = ap_rst_n & ready_c;
  assign bus.ap_done     = ap_rst_n & done_c;
  assign bus.ap_idle     = ~ap_rst_n | (state_q == IDLE);
  assign bus.mul_a       = ap_rst_n ? mul_a_p1_q : '0;
  assign bus.mul_b       = ap_rst_n ? mul_b_p1_q : '0;
  assign bus.addr_tdata  = ap_rst_n ? tdata_p2_q : '0;
  assign bus.addr_tvalid = ap_rst_n & vld_p2_q;
  assign bus.addr_tlast  = ap_rst_n & last_p2_q;

endmodule

// File: tb/tb_cnna_fmap_addr_gen.sv
// Scoreboard bench for cnna_fmap_addr_gen: expected beats come from a nested
// row/col loop model; a negedge monitor pops and compares every handshake.
module tb_cnna_fmap_addr_gen;
  import cnna_addr_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tready_r = 1'b1;
  always #5 clk = ~clk;

  cnna_fmap_addr_gen_if bus();

  cnna_fmap_addr_gen dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus.slave)
  );

  // External 13x5 multiplier, combinational.
  assign bus.mul_p       = ADDR_W'(bus.mul_a) * ADDR_W'(bus.mul_b);
  assign bus.addr_tready = tready_r;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_b;
  beat_t prev_beat;
  logic  prev_stall = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int stall_from = 0;
  int stall_to = 0;
  int first_vld_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  int beats_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tready_r = 1'b1;
      1:       tready_r = ($urandom_range(0, 3) != 0);
      default: tready_r = !(cyc >= stall_from && cyc < stall_to);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_hold_valid", 32'(bus.addr_tvalid), 32'd1);
        chk("stall_hold_data", 32'(bus.addr_tdata), 32'(prev_beat.addr));
        chk("stall_hold_last", 32'(bus.addr_tlast), 32'(prev_beat.last));
      end
      if (bus.addr_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.addr_tvalid && bus.addr_tready) begin
        beats_seen++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr 0x%0h, required no beat (cycle %0d)",
                   bus.addr_tdata, cyc);
        end else begin
          exp_b = exp_q.pop_front();
          chk("beat_addr", 32'(bus.addr_tdata), 32'(exp_b.addr));
          chk("beat_last", 32'(bus.addr_tlast), 32'(exp_b.last));
        end
      end
      if (bus.ap_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.addr_tvalid & ~bus.addr_tready;
      prev_beat  = '{bus.addr_tdata, bus.addr_tlast};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_job(input logic [ADDR_W-1:0] base, input logic [STRIDE_W-1:0] stride,
                          input logic [ROW_W-1:0] rows, input logic [STRIDE_W-1:0] cols);
    beat_t b;
    for (int r = 0; r < int'(rows); r++) begin
      for (int c = 0; c < int'(cols); c++) begin
        b.addr = ADDR_W'(int'(base) + r * int'(stride) + c);
        b.last = (r == int'(rows) - 1) && (c == int'(cols) - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!bus.ap_idle && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle_before_start", 32'(bus.ap_idle), 32'd1);
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] base, input logic [STRIDE_W-1:0] stride,
                         input logic [ROW_W-1:0] rows, input logic [STRIDE_W-1:0] cols,
                         input int lat_exp, input bit stall_beat2);
    int n, t, d0, b0, k;
    n = int'(rows) * int'(cols);
    wait_idle();
    @(posedge clk); #1;
    bus.ap_start   = 1'b1;
    bus.cfg_base   = base;
    bus.cfg_stride = stride;
    bus.cfg_rows   = rows;
    bus.cfg_cols   = cols;
    push_job(base, stride, rows, cols);
    first_vld_cyc = -1;
    d0 = done_cnt;
    b0 = beats_seen;
    @(negedge clk);
    t = cyc;
    chk("ap_ready_at_start", 32'(bus.ap_ready), 32'd1);
    if (stall_beat2) begin
      stall_from = t + 4;
      stall_to   = t + 7;
    end
    if (n > 0) begin
      // Keep start high and scramble cfg while busy: both must be ignored.
      repeat (2) begin
        @(posedge clk); #1;
        bus.cfg_base   = ADDR_W'($urandom);
        bus.cfg_stride = STRIDE_W'($urandom);
        bus.cfg_rows   = ROW_W'($urandom);
        bus.cfg_cols   = STRIDE_W'($urandom);
        @(negedge clk);
        chk("ap_ready_single", 32'(bus.ap_ready), 32'd0);
      end
    end
    @(posedge clk); #1;
    bus.ap_start = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
    if (lat_exp >= 0) chk("done_latency", 32'(done_cyc - t), 32'(lat_exp));
    chk("beat_count", 32'(beats_seen - b0), 32'(n));
    if (n > 0) begin
      chk("first_beat_latency", 32'(first_vld_cyc - t), 32'd3);
      chk("done_after_last_hs", 32'(done_cyc - last_hs_cyc), 32'd1);
    end else begin
      chk("empty_no_valid", 32'(first_vld_cyc), 32'hFFFF_FFFF);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk("done_single_pulse", 32'(done_cnt - d0), 32'd1);
    stall_from = 0;
    stall_to   = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d0, b0, n, lat;
    logic [ROW_W-1:0]    rr;
    logic [STRIDE_W-1:0] cc;
    bus.ap_start   = 1'b0;
    bus.cfg_base   = '0;
    bus.cfg_stride = '0;
    bus.cfg_rows   = '0;
    bus.cfg_cols   = '0;

    // Reset state, with start asserted to prove it is gated.
    repeat (2) @(posedge clk);
    #1 bus.ap_start = 1'b1;
    @(negedge clk);
    chk("rst_ap_ready", 32'(bus.ap_ready), 32'd0);
    chk("rst_ap_done", 32'(bus.ap_done), 32'd0);
    chk("rst_ap_idle", 32'(bus.ap_idle), 32'd1);
    chk("rst_tvalid", 32'(bus.addr_tvalid), 32'd0);
    chk("rst_tlast", 32'(bus.addr_tlast), 32'd0);
    chk("rst_tdata", 32'(bus.addr_tdata), 32'd0);
    chk("rst_mul_a", 32'(bus.mul_a), 32'd0);
    chk("rst_mul_b", 32'(bus.mul_b), 32'd0);
    @(posedge clk); #1;
    bus.ap_start = 1'b0;
    rst_n = 1'b1;

    rdy_mode = 0;
    run_job(18'h00100, 13'd64, 5'd2, 13'd3, 9, 1'b0);
    rdy_mode = 2;
    run_job(18'h00100, 13'd64, 5'd2, 13'd3, 12, 1'b1);
    rdy_mode = 0;
    run_job(18'h00100, 13'd64, 5'd0, 13'd5, 1, 1'b0);
    run_job(18'h00100, 13'd64, 5'd4, 13'd0, 1, 1'b0);
    run_job(18'h3FFFF, 13'd1, 5'd1, 13'd2, 5, 1'b0);
    run_job(18'h00000, 13'd8191, 5'd31, 13'd1, 34, 1'b0);

    // Reset while the third beat is on the bus.
    wait_idle();
    @(posedge clk); #1;
    bus.ap_start   = 1'b1;
    bus.cfg_base   = 18'h00100;
    bus.cfg_stride = 13'd64;
    bus.cfg_rows   = 5'd2;
    bus.cfg_cols   = 13'd3;
    push_job(18'h00100, 13'd64, 5'd2, 13'd3);
    b0 = beats_seen;
    @(negedge clk);
    t = cyc;
    @(posedge clk); #1;
    bus.ap_start = 1'b0;
    while (cyc < t + 4) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_tvalid", 32'(bus.addr_tvalid), 32'd0);
    chk("abort_idle", 32'(bus.ap_idle), 32'd1);
    chk("abort_beats_before", 32'(beats_seen - b0), 32'd2);
    exp_q.delete();
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_job(18'h00100, 13'd64, 5'd2, 13'd3, 9, 1'b0);

    // Randomised jobs under random backpressure.
    repeat (14) begin
      rdy_mode = int'($urandom_range(0, 1));
      rr = ROW_W'($urandom_range(0, 6));
      cc = STRIDE_W'($urandom_range(0, 8));
      n = int'(rr) * int'(cc);
      lat = (rdy_mode == 1) ? -1 : ((n == 0) ? 1 : n + 3);
      run_job(ADDR_W'($urandom), STRIDE_W'($urandom), rr, cc, lat, 1'b0);
    end
    rdy_mode = 0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
